// File: rtl/lamp_serializer.sv
// lamp_serializer: ships the flasher lamp vector to a daisy-chained
// 595-style LED driver over sclk/sdo/latch, resending only on change.
module lamp_serializer #(
  parameter int MAX_LP  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MAX_LP-1:0] lamp,
  output logic              sclk,
  output logic              sdo,
  output logic              latch,
  output logic              busy
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int BW = (MAX_LP > 1) ? $clog2(MAX_LP) : 1;

  localparam logic [DW-1:0] DMAX  = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DHALF = DW'(CLK_DIV);
  localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(MAX_LP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t            state_q, state_d;
  logic [MAX_LP-1:0] shreg_q, shreg_d;
  logic [MAX_LP-1:0] sent_q, sent_d;
  logic              dirty_q, dirty_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              sdo_q, sdo_d;
  logic              latch_q, latch_d;
  logic              busy_q, busy_d;
  logic [DW-1:0]     div_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      sent_q  <= '0;
      dirty_q <= 1'b1;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      sent_q  <= sent_d;
      dirty_q <= dirty_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    sent_d  = sent_q;
    dirty_d = dirty_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    latch_d = latch_q;
    busy_d  = busy_q;
    div_nxt = (div_q == DMAX) ? '0 : div_q + DW'(1);
    unique case (state_q)
      IDLE: begin
        if (dirty_q || (lamp != sent_q)) begin
          shreg_d = lamp;
          sent_d  = lamp;
          dirty_d = 1'b0;
          sdo_d   = lamp[MAX_LP-1];
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        div_d  = div_nxt;
        // sclk rises mid-bit so sdo has CLK_DIV cycles of setup and hold
        sclk_d = (div_nxt >= DHALF);
        if (div_q == DMAX) begin
          if (bit_q == BLAST) begin
            sdo_d   = 1'b0;
            latch_d = 1'b1;
            div_d   = '0;
            state_d = LATCH;
          end else begin
            shreg_d = {shreg_q[MAX_LP-2:0], 1'b0};
            sdo_d   = shreg_q[MAX_LP-2];
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      LATCH: begin
        if (div_q == DLAST) begin
          latch_d = 1'b0;
          busy_d  = 1'b0;
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sclk  = sclk_q;
  assign sdo   = sdo_q;
  assign latch = latch_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_lamp_serializer.sv
// Bench for lamp_serializer: frame model + scoreboard on the default
// instance, directed check of a CLK_DIV=1 / MAX_LP=8 instance.
module tb_lamp_serializer;

  localparam int M     = 16;
  localparam int D     = 2;
  localparam int FRAME = M * 2 * D + D;

  typedef struct {
    logic [M-1:0] v;
    int           t;
  } fr_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [M-1:0] lamp = '0;
  logic         sclk, sdo, latch, busy;
  logic [7:0]   lamp8 = '0;
  logic         sclk2, sdo2, latch2, busy2;

  int total = 0;
  int bad   = 0;

  lamp_serializer #(.MAX_LP(M), .CLK_DIV(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .lamp (lamp),
    .sclk (sclk),
    .sdo  (sdo),
    .latch(latch),
    .busy (busy)
  );

  lamp_serializer #(.MAX_LP(8), .CLK_DIV(1)) dut2 (
    .clk  (clk),
    .rst  (rst),
    .lamp (lamp8),
    .sclk (sclk2),
    .sdo  (sdo2),
    .latch(latch2),
    .busy (busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // frame scheduling model
  fr_t          sb[$];
  int           cyc     = 0;
  int           m_cnt   = 0;
  logic         m_dirty = 1'b1;
  logic [M-1:0] m_sent  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   = 0;
      m_dirty = 1'b1;
      m_sent  = '0;
      sb.delete();
    end else begin
      cyc++;
      if (m_cnt == 0) begin
        if (m_dirty || lamp !== m_sent) begin
          sb.push_back('{lamp, cyc});
          m_sent  = lamp;
          m_dirty = 1'b0;
          m_cnt   = FRAME;
        end
      end else begin
        m_cnt--;
      end
    end
  end

  // receiver model and per-cycle checks, sampled mid-cycle
  logic         sclk_p = 0, latch_p = 0, busy_p = 0;
  logic [M-1:0] rx = '0;
  int           nrise = 0, frames = 0;
  int           brise_t = 0, brise_prev = 0, lrise_t = 0;
  fr_t          f;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      sclk_p  = 0;
      latch_p = 0;
      busy_p  = 0;
      nrise   = 0;
      rx      = '0;
    end else begin
      chk("busy", busy, m_cnt != 0);
      if (latch) chk("latch_sclk", sclk, 0);
      if (sclk && !sclk_p) begin
        rx = {rx[M-2:0], sdo};
        nrise++;
      end
      if (busy && !busy_p) begin
        brise_prev = brise_t;
        brise_t    = cyc;
      end
      if (!busy && busy_p) chk("busy_len", cyc - brise_t, FRAME);
      if (latch && !latch_p) begin
        lrise_t = cyc;
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          f = sb.pop_front();
          chk("data", rx, f.v);
          chk("nsclk", nrise, M);
          chk("latch_t", cyc - f.t, M * 2 * D);
        end
        nrise = 0;
        frames++;
      end
      if (!latch && latch_p) chk("latch_len", cyc - lrise_t, D);
      sclk_p  = sclk;
      latch_p = latch;
      busy_p  = busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_cnt != 0 || m_dirty || lamp !== m_sent) && n < 500);
    chk("idle_to", n < 500, 1);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_to", busy, 1);
  endtask

  task automatic run_small();
    logic [7:0] r8;
    int  bc, nr;
    logic sp, bp, lp;
    r8 = '0;
    bc = 0;
    nr = 0;
    sp = 0;
    bp = 0;
    lp = 0;
    lamp8 = 8'h3C;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy2) bc++;
      if (busy2 && bp && !latch2) chk("sclk_tog", sclk2, !sp);
      if (sclk2 && !sp) begin
        r8 = {r8[6:0], sdo2};
        nr++;
      end
      if (latch2 && !lp) begin
        chk("rx8", r8, 8'h3C);
        chk("nsclk8", nr, 8);
      end
      sp = sclk2;
      bp = busy2;
      lp = latch2;
    end
    chk("len8", bc, 17);
  endtask

  initial begin
    int f0;
    logic [M-1:0] prev;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_idle();
    chk("pwr_frames", frames, 1);
    repeat (5) @(negedge clk);
    chk("pwr_quiet", frames, 1);

    lamp = 16'h8001;
    wait_idle();
    lamp = 16'hA5C3;
    wait_idle();

    f0   = frames;
    lamp = 16'h0001;
    wait_busy();
    repeat (10) @(negedge clk);
    lamp = 16'h0003;
    repeat (20) @(negedge clk);
    lamp = 16'h0007;
    wait_idle();
    chk("chg_frames", frames - f0, 2);
    chk("chg_gap", brise_t - brise_prev, FRAME + 1);

    run_small();

    f0   = frames;
    lamp = 16'h1234;
    wait_busy();
    repeat (8 * 2 * D + 1) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_sclk", sclk, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_latch", latch, 0);
    chk("rst_busy", busy, 0);
    #2 rst = 1'b0;
    wait_idle();
    chk("rst_frames", frames - f0, 1);

    prev = lamp;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) lamp = prev;
        else begin
          prev = lamp;
          lamp = M'($urandom);
        end
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lamp_serializer.md
# lamp_serializer

Downstream stage of the bound flasher. Takes the flasher's 16-bit parallel `lamp` vector and drives it off-chip to a daisy-chained serial-in/parallel-out LED driver (595-style) over a 3-wire link: `sclk`, `sdo` and `latch`. A frame is sent whenever the lamp pattern differs from the last pattern sent, and once after every reset. If `lamp` changes while a frame is in flight, the block keeps only the latest pattern; intermediate patterns are dropped.

## Interface
- `MAX_LP`, default 16: lamp vector width, which is also the number of bits per frame.
- `CLK_DIV`, default 2: system clocks per `sclk` half-period. Must be ≥ 1.
- `clk`  in  1: system clock. All logic is on its rising edge.
- `rst`  in  1: reset. Asynchronous assert, active-high.
- `lamp`  in  MAX_LP: parallel lamp pattern from the flasher. It is registered upstream and is not resynchronised here.
- `sclk`  out  1: serial clock to the driver chain. The receiver samples `sdo` on the `sclk` rising edge.
- `sdo`  out  1: serial data, MSB (`lamp[MAX_LP-1]`) first.
- `latch`  out  1: storage-register strobe. It is high for `CLK_DIV` cycles after the last bit.
- `busy`  out  1: high from frame load until the end of the latch pulse.

All outputs are registered.

## Operation
- Internal state:
  - FSM with states IDLE, SHIFT, LATCH.
  - `shreg[MAX_LP-1:0]` shift register.
  - `sent[MAX_LP-1:0]` holds the last pattern loaded.
  - `dirty` flag.
  - `div_cnt`, range 0..2·CLK_DIV−1.
  - `bit_cnt`, range 0..MAX_LP−1.
- Reset (async, `rst`=1):
  - state=IDLE; `sclk`=0, `sdo`=0, `latch`=0, `busy`=0.
  - `shreg`=0, `sent`=0, `dirty`=1; both counters 0.
- IDLE, at a clock edge where `dirty`=1 or `lamp`≠`sent`:
  - Load `shreg`←`lamp`, `sent`←`lamp`, `dirty`←0.
  - Set `sdo`←`lamp[MAX_LP-1]`, `sclk`←0, `busy`←1.
  - Clear both counters and move to SHIFT.
  - Otherwise stay in IDLE and hold all outputs.
- SHIFT, on every edge:
  - `div_cnt` increments.
  - `sclk` is 0 while `div_cnt`<CLK_DIV and 1 for the rest of the bit.
  - When `div_cnt` wraps from 2·CLK_DIV−1 to 0 and `bit_cnt`<MAX_LP−1: shift `shreg` left, drive `sdo` with the next bit, increment `bit_cnt`, set `sclk` to 0.
  - When `div_cnt` wraps and `bit_cnt`=MAX_LP−1: set `sclk`←0, `sdo`←0, `latch`←1, and move to LATCH.
- LATCH:
  - Hold `latch`=1 for CLK_DIV cycles.
  - Then set `latch`←0, `busy`←0, and move to IDLE.
- `lamp` is not sampled during SHIFT or LATCH. The compare in IDLE picks up whatever pattern is present then. A change that returns to `sent` before IDLE produces no frame.
- The `lamp` input must not affect the bits of a frame already loaded.

## Timing
- Let E0 be the load edge, i.e. the first IDLE edge with a pending change. `busy` rises at E0.
- Each bit lasts 2·CLK_DIV cycles. Bit k's `sclk` rising edge is at E0 + k·2·CLK_DIV + CLK_DIV.
- `sdo` is stable for CLK_DIV cycles on each side of every `sclk` rise.
- `latch` rises at E0 + MAX_LP·2·CLK_DIV and falls CLK_DIV cycles later. `busy` falls on the same edge as `latch`.
- Frame length is MAX_LP·2·CLK_DIV + CLK_DIV cycles; for the defaults, 66 cycles.
- Each frame has exactly MAX_LP `sclk` rising edges and one latch pulse. `latch` and `sclk` are never high together.
- After the end of a frame, `busy` is low for at least one cycle. With a pending change, the next load occurs one edge after `busy` falls; for the defaults, back-to-back frames start 67 cycles apart.
- Reset mid-frame:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - No partial latch pulse is produced.
  - On the first edge after `rst` deasserts, `dirty`=1 forces a full frame.
- With `rst` held high, no outputs toggle.

## Test plan
- **Power-up frame.** Apply reset, then release it with `lamp`=0. Required: `busy` rises on the first edge and stays high 66 cycles; 16 `sclk` rises with `sdo`=0 at each; one 2-cycle `latch` pulse; then idle with no further activity.
- **Bit order.** Set `lamp`=16'h8001 from idle. Required: the receiver model shifts in 1,0×14,1, and its parallel output after `latch` equals 16'h8001. Repeat with 16'hA5C3.
- **Change during a frame.** Set `lamp`=16'h0001; at cycle 10 of the frame change it to 16'h0003, then at cycle 30 change it to 16'h0007. Required: exactly two frames, 0001 then 0007, with the second frame starting 67 cycles after the first.
- **Async reset mid-frame.** Assert `rst` for 3 ns, off the clock edge, during bit 8. Required: `sclk`, `sdo`, `latch` and `busy` all read 0 before the next edge; no latch pulse; after release, a full frame of the current `lamp` value.
- **CLK_DIV=1, MAX_LP=8.** Set `lamp`=8'h3C. Required: `sclk` toggles every cycle; frame length 17 cycles; receiver output 8'h3C.
- **Chained with bound_flasher.** Connect `lamp` to the flasher, drive `flick` per its normal case, and run 1000 cycles. Required: every latched receiver value equals `lamp` at its load edge, and no two frames overlap.
